// File: rtl/aes_pkg.sv
// Shared AES types, S-box tables and word/state helpers used by the encryptor and aes_decrypt.
package aes_pkg;

   typedef logic [127:0] aes_128;
   typedef logic [255:0] key_256;

   typedef enum logic [2:0] {
      NOOP    = 3'd0,
      ENC_128 = 3'd1,
      ENC_192 = 3'd2,
      ENC_256 = 3'd3,
      DEC_128 = 3'd4,
      DEC_192 = 3'd5,
      DEC_256 = 3'd6
   } mode;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_KEXP  = 3'd1,
      S_ADDK  = 3'd2,
      S_ROUND = 3'd3,
      S_DONE  = 3'd4
   } dec_state_e;

   localparam logic [2047:0] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   localparam logic [2047:0] INV_SBOX_TBL = {
      128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};

   // Byte x lives at the x-th byte from the MSB end of the table.
   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX_TBL[{~b, 3'b000} +: 8];
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] b);
      return INV_SBOX_TBL[{~b, 3'b000} +: 8];
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] i);
      case (i)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic logic [31:0] rot_word(input logic [31:0] w);
      return {w[23:0], w[31:24]};
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // Multiply by a 4-bit constant k in GF(2^8) (bits select b, 2b, 4b, 8b).
   function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] k);
      logic [7:0] x2, x4, x8;
      x2 = xtime(b);
      x4 = xtime(x2);
      x8 = xtime(x4);
      return (k[0] ? b : 8'h00) ^ (k[1] ? x2 : 8'h00) ^
             (k[2] ? x4 : 8'h00) ^ (k[3] ? x8 : 8'h00);
   endfunction

   function automatic logic [31:0] inv_mix_col(input logic [31:0] w);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = w;
      return {gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9),
              gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd),
              gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb),
              gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he)};
   endfunction

   function automatic aes_128 inv_mix_columns(input aes_128 s);
      aes_128 o;
      for (int c = 0; c < 4; c++) begin
         o[127 - 32*c -: 32] = inv_mix_col(s[127 - 32*c -: 32]);
      end
      return o;
   endfunction

   // Byte (row r, column c) sits at index 4c+r counted from the MSB; row r rotates right by r.
   function automatic aes_128 inv_shift_rows(input aes_128 s);
      aes_128 o;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + 4 - r) % 4) + r) -: 8];
         end
      end
      return o;
   endfunction

   function automatic aes_128 inv_sub_bytes(input aes_128 s);
      aes_128 o;
      for (int i = 0; i < 16; i++) begin
         o[8*i +: 8] = inv_sbox(s[8*i +: 8]);
      end
      return o;
   endfunction

   function automatic logic is_dec(input logic [2:0] m);
      return (m == DEC_128) || (m == DEC_192) || (m == DEC_256);
   endfunction

   function automatic logic [3:0] nk_of(input logic [2:0] m);
      case (m)
         DEC_192, ENC_192: return 4'd6;
         DEC_256, ENC_256: return 4'd8;
         default:          return 4'd4;
      endcase
   endfunction

   function automatic logic [3:0] nr_of(input logic [2:0] m);
      case (m)
         DEC_192, ENC_192: return 4'd12;
         DEC_256, ENC_256: return 4'd14;
         default:          return 4'd10;
      endcase
   endfunction

   // Index of the final expanded word, 4*(Nr+1)-1.
   function automatic logic [5:0] last_w_of(input logic [2:0] m);
      case (m)
         DEC_192, ENC_192: return 6'd51;
         DEC_256, ENC_256: return 6'd59;
         default:          return 6'd43;
      endcase
   endfunction

   function automatic logic [255:0] key_mask(input logic [2:0] m);
      case (m)
         DEC_128, ENC_128: return {{128{1'b1}}, {128{1'b0}}};
         DEC_192, ENC_192: return {{192{1'b1}}, {64{1'b0}}};
         default:          return {256{1'b1}};
      endcase
   endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round; InvMixColumns is bypassed when last is set.
module aes_inv_round
   import aes_pkg::*;
(
   input  logic [127:0] state,
   input  logic [127:0] rk,
   input  logic         last,
   output logic [127:0] next_state
);

   logic [127:0] ark_s;

   // Inverse round datapath.
   always_comb begin
      ark_s = inv_sub_bytes(inv_shift_rows(state)) ^ rk;
      if (last) begin
         next_state = ark_s;
      end else begin
         next_state = inv_mix_columns(ark_s);
      end
   end

endmodule

// File: rtl/aes_decrypt.sv
// AES inverse cipher, 128/192/256-bit keys: word-serial key expansion, then one inverse round per cycle.
// Defining AES_DEC_KEY_CACHE_EN lets a request with the previously expanded key skip key expansion.
module aes_decrypt
   import aes_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic [127:0] data_i,
   input  logic [255:0] key_i,
   input  logic [2:0]   mode_i,
   output logic [127:0] data_o,
   output logic         data_valid_o,
   output logic         ready_o
);

   dec_state_e   state_r, next_state_s;
   logic [127:0] ct_r, st_r, data_r, rk_s, round_out_s;
   logic [31:0]  w_r [0:59];
   logic [31:0]  temp_s, temp_x_s, new_w_s;
   logic [3:0]   nk_r, nr_r, rnd_r, rci_r, rk_sel_s;
   logic [5:0]   idx_r, last_w_r;
   logic [2:0]   kc_r;
   logic         valid_r, ready_r, accept_s, hit_s, kexp_done_s;

   assign accept_s     = (state_r == S_IDLE) && is_dec(mode_i);
   assign kexp_done_s  = (state_r == S_KEXP) && (idx_r == last_w_r);
   assign rk_sel_s     = (state_r == S_ADDK) ? nr_r : rnd_r;
   assign data_o       = data_r;
   assign data_valid_o = valid_r;
   assign ready_o      = ready_r;

`ifdef AES_DEC_KEY_CACHE_EN
   logic         cache_valid_r;
   logic [2:0]   cache_mode_r;
   logic [255:0] cache_key_r;

   assign hit_s = cache_valid_r && (cache_mode_r == mode_i) &&
                  ((key_i & key_mask(mode_i)) == cache_key_r);

   // Key cache: tag captured on a miss, valid once that expansion completes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cache_valid_r <= 1'b0;
         cache_mode_r  <= 3'd0;
         cache_key_r   <= 256'd0;
      end else if (accept_s && !hit_s) begin
         cache_valid_r <= 1'b0;
         cache_mode_r  <= mode_i;
         cache_key_r   <= key_i & key_mask(mode_i);
      end else if (kexp_done_s) begin
         cache_valid_r <= 1'b1;
      end
   end
`else
   assign hit_s = 1'b0;
`endif

   // Key schedule word w[idx] from w[idx-1] and w[idx-Nk]; kc_r tracks idx mod Nk.
   always_comb begin
      temp_s = w_r[idx_r - 6'd1];
      if (kc_r == 3'd0) begin
         temp_x_s = sub_word(rot_word(temp_s)) ^ {rcon(rci_r), 24'h000000};
      end else if ((nk_r == 4'd8) && (kc_r == 3'd4)) begin
         temp_x_s = sub_word(temp_s);
      end else begin
         temp_x_s = temp_s;
      end
      new_w_s = w_r[idx_r - {2'b00, nk_r}] ^ temp_x_s;
      rk_s    = {w_r[{rk_sel_s, 2'b00}], w_r[{rk_sel_s, 2'b01}],
                 w_r[{rk_sel_s, 2'b10}], w_r[{rk_sel_s, 2'b11}]};
   end

   aes_inv_round u_inv_round (
      .state      (st_r),
      .rk         (rk_s),
      .last       (rnd_r == 4'd0),
      .next_state (round_out_s)
   );

   // Next-state logic.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         S_IDLE: begin
            if (!accept_s) begin
               next_state_s = S_IDLE;
            end else if (hit_s) begin
               next_state_s = S_ADDK;
            end else begin
               next_state_s = S_KEXP;
            end
         end
         S_KEXP: begin
            if (kexp_done_s) begin
               next_state_s = S_ADDK;
            end else begin
               next_state_s = S_KEXP;
            end
         end
         S_ADDK:  next_state_s = S_ROUND;
         S_ROUND: begin
            if (rnd_r == 4'd0) begin
               next_state_s = S_DONE;
            end else begin
               next_state_s = S_ROUND;
            end
         end
         S_DONE:  next_state_s = S_IDLE;
         default: next_state_s = S_IDLE;
      endcase
   end

   // State register and registered handshake outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= S_IDLE;
         valid_r <= 1'b0;
         ready_r <= 1'b1;
      end else begin
         state_r <= next_state_s;
         valid_r <= (next_state_s == S_DONE);
         ready_r <= (next_state_s == S_IDLE);
      end
   end

   // Round-key buffer; on a cache hit the previous expansion is left intact.
   always_ff @(posedge clk) begin
      if (accept_s && !hit_s) begin
         for (int i = 0; i < 8; i++) begin
            w_r[i] <= key_i[255 - 32*i -: 32];
         end
      end else if (state_r == S_KEXP) begin
         w_r[idx_r] <= new_w_s;
      end else begin
         w_r[0] <= w_r[0];
      end
   end

   // Run control, cipher state and result register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ct_r     <= 128'd0;
         st_r     <= 128'd0;
         data_r   <= 128'd0;
         nk_r     <= 4'd4;
         nr_r     <= 4'd10;
         last_w_r <= 6'd43;
         idx_r    <= 6'd0;
         kc_r     <= 3'd0;
         rci_r    <= 4'd1;
         rnd_r    <= 4'd0;
      end else begin
         case (state_r)
            S_IDLE: begin
               if (accept_s) begin
                  ct_r     <= data_i;
                  nk_r     <= nk_of(mode_i);
                  nr_r     <= nr_of(mode_i);
                  last_w_r <= last_w_of(mode_i);
                  idx_r    <= {2'b00, nk_of(mode_i)};
                  kc_r     <= 3'd0;
                  rci_r    <= 4'd1;
               end
            end
            S_KEXP: begin
               idx_r <= idx_r + 6'd1;
               // Nk-1 in three bits: 3, 5 or 7 (Nk = 8 wraps to 0).
               if (kc_r == (nk_r[2:0] - 3'd1)) begin
                  kc_r  <= 3'd0;
                  rci_r <= rci_r + 4'd1;
               end else begin
                  kc_r  <= kc_r + 3'd1;
               end
            end
            S_ADDK: begin
               st_r  <= ct_r ^ rk_s;
               rnd_r <= nr_r - 4'd1;
            end
            S_ROUND: begin
               st_r <= round_out_s;
               if (rnd_r == 4'd0) begin
                  data_r <= round_out_s;
               end else begin
                  rnd_r <= rnd_r - 4'd1;
               end
            end
            default: begin
               st_r <= st_r;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_aes_decrypt.sv
// Directed FIPS-197 vectors for aes_decrypt: plaintext, latency, handshake, reset and illegal modes.
module tb_aes_decrypt;
   import aes_pkg::*;

   logic         clk, rst;
   logic [127:0] data_i;
   logic [255:0] key_i;
   logic [2:0]   mode_i;
   logic [127:0] data_o;
   logic         data_valid_o, ready_o;
   int           n_checks, n_fail;

`ifdef AES_DEC_KEY_CACHE_EN
   localparam int HIT_LAT = 11;
`else
   localparam int HIT_LAT = 51;
`endif

   localparam logic [127:0] PT_STD = 128'h00112233445566778899aabbccddeeff;
   localparam logic [255:0] K128   = {128'h000102030405060708090a0b0c0d0e0f, 128'hdeadbeef0badf00d1234567890abcdef};
   localparam logic [255:0] K128_B = {128'h000102030405060708090a0b0c0d0e0f, 128'h5555aaaa3333cccc0f0f0f0ff0f0f0f0};
   localparam logic [255:0] K128_F = {128'h800102030405060708090a0b0c0d0e0f, 128'hdeadbeef0badf00d1234567890abcdef};
   localparam logic [255:0] KFIPS  = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
   localparam logic [255:0] K192   = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'hcafef00dfeedbeef};
   localparam logic [255:0] K256   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
   localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;

   aes_decrypt dut (
      .clk          (clk),
      .rst          (rst),
      .data_i       (data_i),
      .key_i        (key_i),
      .mode_i       (mode_i),
      .data_o       (data_o),
      .data_valid_o (data_valid_o),
      .ready_o      (ready_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One request: accept, scramble inputs, measure latency, check result and handshake.
   task automatic run_dec(input string tag, input logic [2:0] m, input logic [255:0] k,
                          input logic [127:0] ct, input logic [127:0] pt, input int exp_lat,
                          input logic chk_pt);
      int lat;
      @(negedge clk);
      mode_i = m;
      key_i  = k;
      data_i = ct;
      @(posedge clk);
      #1;
      mode_i = NOOP;
      key_i  = {8{$urandom()}};
      data_i = {4{$urandom()}};
      check_eq({tag, "_ready_low"}, {127'd0, ready_o}, 128'd0);
      lat = 0;
      while (!data_valid_o && lat < 200) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check_eq({tag, "_latency"}, 128'(lat), 128'(exp_lat));
      if (chk_pt) begin
         check_eq({tag, "_pt"}, data_o, pt);
      end
      @(posedge clk);
      #1;
      check_eq({tag, "_valid_pulse"}, {127'd0, data_valid_o}, 128'd0);
      check_eq({tag, "_ready_back"}, {127'd0, ready_o}, 128'd1);
      if (chk_pt) begin
         check_eq({tag, "_pt_held"}, data_o, pt);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic seen;
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b1;
      mode_i   = NOOP;
      key_i    = 256'd0;
      data_i   = 128'd0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("reset_data", data_o, 128'd0);
      check_eq("reset_valid", {127'd0, data_valid_o}, 128'd0);
      check_eq("reset_ready", {127'd0, ready_o}, 128'd1);
      @(negedge clk);
      rst = 1'b0;

      run_dec("c1_128",    DEC_128, K128,   CT128, PT_STD, 51, 1'b1);
      run_dec("c1_repeat", DEC_128, K128_B, CT128, PT_STD, HIT_LAT, 1'b1);
      run_dec("c1_flip",   DEC_128, K128_F, CT128, PT_STD, 51, 1'b0);
      run_dec("fips_b",    DEC_128, KFIPS,  128'h3925841d02dc09fbdc118597196a0b32,
              128'h3243f6a8885a308d313198a2e0370734, 51, 1'b1);
      run_dec("c2_192",    DEC_192, K192,   CT192, PT_STD, 59, 1'b1);
      run_dec("c3_256",    DEC_256, K256,   CT256, PT_STD, 67, 1'b1);

      // Asynchronous reset twenty cycles into a DEC_256 run.
      @(negedge clk);
      mode_i = DEC_256;
      key_i  = K256;
      data_i = CT256;
      @(posedge clk);
      #1;
      mode_i = NOOP;
      repeat (20) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check_eq("midrst_data", data_o, 128'd0);
      check_eq("midrst_valid", {127'd0, data_valid_o}, 128'd0);
      check_eq("midrst_ready", {127'd0, ready_o}, 128'd1);
      @(negedge clk);
      rst  = 1'b0;
      seen = 1'b0;
      repeat (70) begin
         @(posedge clk);
         #1;
         if (data_valid_o) seen = 1'b1;
      end
      check_eq("midrst_no_valid", {127'd0, seen}, 128'd0);
      check_eq("midrst_data_zero", data_o, 128'd0);

      // Encrypt modes must not start a run.
      @(negedge clk);
      mode_i = ENC_128;
      key_i  = K128;
      data_i = CT128;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         check_eq($sformatf("enc_ready_%0d", i), {127'd0, ready_o}, 128'd1);
      end
      @(negedge clk);
      mode_i = NOOP;

      // Reset invalidated any cached key, so the full expansion runs again.
      run_dec("post_rst", DEC_128, K128, CT128, PT_STD, 51, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
